// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready handshake,
// optional 2-entry skid buffer, synchronous flush and saturating stall counter.
module pipe_stage_reg #(
  parameter int WIDTH = 96,
  parameter bit SKID = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             main_v;
  logic [WIDTH-1:0] main_d;
  logic             acc;
  logic             pop;

  assign acc       = in_valid && in_ready;
  assign pop       = main_v && out_ready;
  assign out_valid = main_v;
  assign out_data  = main_d;

  generate
    if (SKID) begin : g_skid
      logic             skid_v;
      logic [WIDTH-1:0] skid_d;

      // ready depends only on state, never on out_ready
      assign in_ready = !skid_v;

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          main_v <= 1'b0;
          main_d <= '0;
          skid_v <= 1'b0;
          skid_d <= '0;
        end else if (flush) begin
          main_v <= 1'b0;
          main_d <= '0;
          skid_v <= 1'b0;
          skid_d <= '0;
        end else if (pop) begin
          if (skid_v) begin
            main_d <= skid_d;
            if (acc) begin
              skid_d <= in_data;
            end else begin
              skid_v <= 1'b0;
              skid_d <= '0;
            end
          end else begin
            main_v <= acc;
            main_d <= acc ? in_data : '0;
          end
        end else if (acc) begin
          if (!main_v) begin
            main_v <= 1'b1;
            main_d <= in_data;
          end else begin
            skid_v <= 1'b1;
            skid_d <= in_data;
          end
        end
      end

      a_skid_main: assert property (
        @(posedge CLK) disable iff (!nRST) skid_v |-> main_v);
    end else begin : g_noskid
      assign in_ready = !main_v || out_ready;

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          main_v <= 1'b0;
          main_d <= '0;
        end else if (flush) begin
          main_v <= 1'b0;
          main_d <= '0;
        end else if (acc) begin
          main_v <= 1'b1;
          main_d <= in_data;
        end else if (pop) begin
          main_v <= 1'b0;
          main_d <= '0;
        end
      end
    end
  endgenerate

  logic [CNT_W-1:0] one;
  assign one = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (!flush && main_v && !out_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + one;
    end
  end

  a_bubble_zero: assert property (
    @(posedge CLK) disable iff (!nRST) !out_valid |-> out_data == '0);
  a_no_x: assert property (
    @(posedge CLK) disable iff (!nRST)
    !$isunknown({out_valid, out_data, in_ready, stall_cnt}));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg with SKID=1,
// SKID=0 and a 4-bit stall counter instance sharing one stimulus stream.
module tb_pipe_stage_reg;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [95:0] in_data;

  logic        rdy0, vld0, rdy1, vld1, rdy2, vld2;
  logic [95:0] dat0, dat1, dat2;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  int checks = 0;
  int failures = 0;

  logic [95:0] q0[$];
  logic [95:0] q1[$];
  logic        p0, p1;
  logic [95:0] g0, e0, g1, e1;
  int          sz0, sz1;
  logic        c_rdy0, c_vld0, c_rdy1, c_vld1;
  logic [95:0] c_dat0, c_dat1;
  logic [15:0] c_cnt0;

  always #5 CLK = ~CLK;

  pipe_stage_reg #(.WIDTH(96), .SKID(1'b1), .CNT_W(16)) u0 (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .out_valid(vld0), .out_ready(out_ready), .out_data(dat0),
    .stall_cnt(cnt0));

  pipe_stage_reg #(.WIDTH(96), .SKID(1'b0), .CNT_W(16)) u1 (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .out_valid(vld1), .out_ready(out_ready), .out_data(dat1),
    .stall_cnt(cnt1));

  pipe_stage_reg #(.WIDTH(96), .SKID(1'b1), .CNT_W(4)) u2 (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
    .out_valid(vld2), .out_ready(out_ready), .out_data(dat2),
    .stall_cnt(cnt2));

  function automatic logic [95:0] pay(input logic [7:0] tag, input int i);
    logic [31:0] w;
    w = {tag, 24'h0} + 32'(i);
    return {w, ~w, w ^ 32'h5A5A_5A5A};
  endfunction

  // One clock: drive at negedge, sample 2ns later, record handshakes.
  task automatic step(input logic v, input logic [95:0] d,
                      input logic r, input logic f);
    in_valid = v; in_data = d; out_ready = r; flush = f;
    #2;
    sz0 = q0.size(); sz1 = q1.size();
    c_rdy0 = rdy0; c_vld0 = vld0; c_dat0 = dat0; c_cnt0 = cnt0;
    c_rdy1 = rdy1; c_vld1 = vld1; c_dat1 = dat1;
    p0 = 1'b0; p1 = 1'b0;
    if (!f) begin
      if (vld0 && r) begin
        p0 = 1'b1; g0 = dat0;
        if (sz0 > 0) e0 = q0.pop_front(); else e0 = {96{1'bx}};
      end
      if (vld1 && r) begin
        p1 = 1'b1; g1 = dat1;
        if (sz1 > 0) e1 = q1.pop_front(); else e1 = {96{1'bx}};
      end
      if (v && rdy0) q0.push_back(d);
      if (v && rdy1) q1.push_back(d);
    end
    @(negedge CLK);
    if (f) begin q0.delete(); q1.delete(); end
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    nRST = 1'b0;
    #3;
    nRST = 1'b1;
    @(negedge CLK);
    q0.delete(); q1.delete();
  endtask

  task automatic test_reset();
    do_reset();
    step(1'b1, pay(8'hF1, 1), 1'b0, 1'b0);
    step(1'b1, pay(8'hF1, 2), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    checks++;
    if (rdy0 !== 1'b0) begin failures++;
      $display("FAIL rst_pre_ready got=%b exp=0", rdy0); end
    checks++;
    if (cnt0 !== 16'd1) begin failures++;
      $display("FAIL rst_pre_cnt got=%0d exp=1", cnt0); end
    nRST = 1'b0;
    #1;
    checks++;
    if (vld0 !== 1'b0) begin failures++;
      $display("FAIL rst_valid got=%b exp=0", vld0); end
    checks++;
    if (dat0 !== 96'h0) begin failures++;
      $display("FAIL rst_data got=%h exp=0", dat0); end
    checks++;
    if (rdy0 !== 1'b1) begin failures++;
      $display("FAIL rst_ready got=%b exp=1", rdy0); end
    checks++;
    if (cnt0 !== 16'd0) begin failures++;
      $display("FAIL rst_cnt got=%0d exp=0", cnt0); end
    #1;
    nRST = 1'b1;
    @(negedge CLK);
    checks++;
    if (vld0 !== 1'b0) begin failures++;
      $display("FAIL rst_after_valid got=%b exp=0", vld0); end
    q0.delete(); q1.delete();
  endtask

  task automatic test_stream();
    int pops = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(i < 8, (i < 8) ? pay(8'hA0, i + 1) : 96'h0, 1'b1, 1'b0);
      if (i < 8) begin
        checks++;
        if (c_rdy0 !== 1'b1) begin failures++;
          $display("FAIL stream_ready got=%b exp=1 i=%0d", c_rdy0, i); end
      end
      if (i >= 1 && i <= 8) begin
        checks++;
        if (c_vld0 !== 1'b1) begin failures++;
          $display("FAIL stream_bubble got=%b exp=1 i=%0d", c_vld0, i); end
      end
      if (p0) begin
        pops++;
        checks++;
        if (g0 !== e0) begin failures++;
          $display("FAIL stream_data got=%h exp=%h", g0, e0); end
      end
    end
    checks++;
    if (pops != 8) begin failures++;
      $display("FAIL stream_count got=%0d exp=8", pops); end
  endtask

  task automatic test_backpressure();
    int pops = 0;
    do_reset();
    step(1'b1, pay(8'hB0, 1), 1'b0, 1'b0);
    step(1'b1, pay(8'hB0, 2), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, pay(8'hB0, 3), 1'b0, 1'b0);
      checks++;
      if (c_rdy0 !== 1'b0) begin failures++;
        $display("FAIL bp_ready got=%b exp=0", c_rdy0); end
    end
    step(1'b1, pay(8'hB0, 3), 1'b1, 1'b0);
    checks++;
    if (c_cnt0 !== 16'd3) begin failures++;
      $display("FAIL bp_stall got=%0d exp=3", c_cnt0); end
    checks++;
    if (c_dat0 !== pay(8'hB0, 1)) begin failures++;
      $display("FAIL bp_main got=%h exp=%h", c_dat0, pay(8'hB0, 1)); end
    if (p0) pops++;
    step(1'b1, pay(8'hB0, 3), 1'b1, 1'b0);
    checks++;
    if (g0 !== e0 || !p0) begin failures++;
      $display("FAIL bp_order2 got=%h exp=%h", g0, e0); end
    if (p0) pops++;
    step(1'b0, 96'h0, 1'b1, 1'b0);
    checks++;
    if (g0 !== e0 || !p0) begin failures++;
      $display("FAIL bp_order3 got=%h exp=%h", g0, e0); end
    if (p0) pops++;
    checks++;
    if (pops != 3 || q0.size() != 0) begin failures++;
      $display("FAIL bp_count got=%0d exp=3", pops); end
  endtask

  task automatic test_flush();
    do_reset();
    step(1'b1, pay(8'hC0, 1), 1'b0, 1'b0);
    step(1'b1, pay(8'hC0, 2), 1'b0, 1'b0);
    step(1'b1, pay(8'hC0, 3), 1'b0, 1'b1);
    in_valid = 1'b0; flush = 1'b0;
    #2;
    checks++;
    if (vld0 !== 1'b0) begin failures++;
      $display("FAIL flush_valid got=%b exp=0", vld0); end
    checks++;
    if (dat0 !== 96'h0) begin failures++;
      $display("FAIL flush_data got=%h exp=0", dat0); end
    checks++;
    if (rdy0 !== 1'b1) begin failures++;
      $display("FAIL flush_ready got=%b exp=1", rdy0); end
    checks++;
    if (cnt0 !== 16'd1) begin failures++;
      $display("FAIL flush_cnt got=%0d exp=1", cnt0); end
    checks++;
    if (vld1 !== 1'b0) begin failures++;
      $display("FAIL flush_valid_s0 got=%b exp=0", vld1); end
    @(negedge CLK);
    step(1'b1, pay(8'hC0, 4), 1'b1, 1'b1);
    in_valid = 1'b0; flush = 1'b0;
    #2;
    checks++;
    if (vld0 !== 1'b0 || dat0 !== 96'h0) begin failures++;
      $display("FAIL flush_drop got=%b/%h exp=0/0", vld0, dat0); end
    @(negedge CLK);
    step(1'b1, pay(8'hC0, 5), 1'b1, 1'b0);
    step(1'b0, 96'h0, 1'b1, 1'b0);
    checks++;
    if (!p0 || g0 !== e0) begin failures++;
      $display("FAIL flush_resume got=%h exp=%h", g0, e0); end
  endtask

  task automatic test_skid0();
    do_reset();
    step(1'b1, pay(8'hD0, 1), 1'b0, 1'b0);
    in_valid = 1'b1; in_data = pay(8'hD0, 2); out_ready = 1'b0;
    #1;
    checks++;
    if (rdy1 !== 1'b0) begin failures++;
      $display("FAIL s0_ready_lo got=%b exp=0", rdy1); end
    checks++;
    if (dat1 !== pay(8'hD0, 1)) begin failures++;
      $display("FAIL s0_main got=%h exp=%h", dat1, pay(8'hD0, 1)); end
    out_ready = 1'b1;
    #1;
    checks++;
    if (rdy1 !== 1'b1) begin failures++;
      $display("FAIL s0_ready_hi got=%b exp=1", rdy1); end
    @(negedge CLK);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (vld1 !== 1'b1 || dat1 !== pay(8'hD0, 2)) begin failures++;
      $display("FAIL s0_replace got=%b/%h exp=1/%h", vld1, dat1,
               pay(8'hD0, 2)); end
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    #1;
    checks++;
    if (vld1 !== 1'b0 || dat1 !== 96'h0) begin failures++;
      $display("FAIL s0_drain got=%b/%h exp=0/0", vld1, dat1); end
    @(negedge CLK);
  endtask

  task automatic test_saturation();
    logic [3:0] exp_c;
    do_reset();
    step(1'b1, pay(8'hE0, 1), 1'b0, 1'b0);
    for (int k = 1; k <= 23; k++) begin
      step(1'b0, 96'h0, 1'b0, 1'b0);
      if (k == 10 || k == 15 || k == 20 || k == 23) begin
        exp_c = (k > 15) ? 4'd15 : 4'(k);
        checks++;
        if (cnt2 !== exp_c) begin failures++;
          $display("FAIL sat_cnt got=%0d exp=%0d k=%0d", cnt2, exp_c, k); end
      end
      if (k == 20) begin
        checks++;
        if (cnt0 !== 16'd20) begin failures++;
          $display("FAIL sat_wide got=%0d exp=20", cnt0); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_stall = 0;
    logic v, r, f;
    logic [95:0] d;
    do_reset();
    for (int n = 0; n < 304; n++) begin
      if (n < 300) begin
        v = 1'($urandom_range(0, 1));
        d = {$urandom, $urandom, $urandom};
        r = ($urandom_range(0, 9) < 7);
        f = ($urandom_range(0, 49) == 0);
      end else begin
        v = 1'b0; d = '0; r = 1'b1; f = 1'b0;
      end
      step(v, d, r, f);
      if (sz0 > 0 && !r && !f) exp_stall++;
      checks++;
      if (c_rdy0 !== (sz0 < 2)) begin failures++;
        $display("FAIL b2b_ready got=%b exp=%b n=%0d", c_rdy0, sz0 < 2, n); end
      checks++;
      if (c_vld0 !== (sz0 > 0)) begin failures++;
        $display("FAIL b2b_valid got=%b exp=%b n=%0d", c_vld0, sz0 > 0, n); end
      checks++;
      if (c_rdy1 !== (sz1 == 0 || r)) begin failures++;
        $display("FAIL b2b_ready_s0 got=%b n=%0d", c_rdy1, n); end
      if (!c_vld0) begin
        checks++;
        if (c_dat0 !== 96'h0) begin failures++;
          $display("FAIL b2b_bubble got=%h exp=0", c_dat0); end
      end
      if (p0) begin
        checks++;
        if (g0 !== e0) begin failures++;
          $display("FAIL b2b_data got=%h exp=%h n=%0d", g0, e0, n); end
      end
      if (p1) begin
        checks++;
        if (g1 !== e1) begin failures++;
          $display("FAIL b2b_data_s0 got=%h exp=%h n=%0d", g1, e1, n); end
      end
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin failures++;
      $display("FAIL b2b_drain got=%0d/%0d exp=0/0", q0.size(), q1.size()); end
    checks++;
    if (cnt0 !== 16'(exp_stall)) begin failures++;
      $display("FAIL b2b_stall got=%0d exp=%0d", cnt0, exp_stall); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_skid0();
    test_saturation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
